// File: rtl/regfile_pkg.sv
// Shared register-file geometry for the writeback arbiter and its neighbours.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);
  int w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_valid[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
        o_any        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the RF write port plus a pending-destination scoreboard for issue stalls.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int XLEN       = regfile_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_rd,
  input  logic [NUM_REQ*XLEN-1:0]        req_data,
  input  logic                           iss_valid,
  input  logic [REG_ADDR_W-1:0]          iss_rd,
  input  logic [REG_ADDR_W-1:0]          iss_rs1,
  input  logic [REG_ADDR_W-1:0]          iss_rs2,
  output logic                           iss_stall,
  output logic                           rf_we,
  output logic [REG_ADDR_W-1:0]          rf_waddr,
  output logic [XLEN-1:0]                rf_wdata
);
  localparam int IW    = $clog2(NUM_REQ);
  localparam int NREGS = 1 << REG_ADDR_W;

  logic [IW-1:0]         r_ptr;
  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic [XLEN-1:0]       r_wdata;
  logic [NREGS-1:0]      r_busy;

  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_idx;
  logic                  w_any;
  logic                  w_accept;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_iss_set;
  logic [NREGS-1:0]      w_busy_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants are masked while reset is held so nothing is accepted and then lost.
  assign req_ready  = w_grant & {NUM_REQ{rst_n}};
  assign w_accept   = w_any & rst_n;
  assign w_sel_rd   = req_rd[w_idx*REG_ADDR_W +: REG_ADDR_W];
  assign w_sel_data = req_data[w_idx*XLEN +: XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_accept && (w_sel_rd != REG_ADDR_W'(REG_ZERO));
      if (w_accept) begin
        r_ptr   <= (w_idx == IW'(NUM_REQ-1)) ? '0 : w_idx + 1'b1;
        r_waddr <= w_sel_rd;
        r_wdata <= w_sel_data;
      end
    end
  end

  assign iss_stall = iss_valid & (r_busy[iss_rs1] | r_busy[iss_rs2] | r_busy[iss_rd]);
  assign w_iss_set = iss_valid & ~iss_stall & (iss_rd != REG_ADDR_W'(REG_ZERO));

  // Clear first so a same-edge issue to the committing index keeps it pending.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we)      w_busy_nxt[r_waddr] = 1'b0;
    if (w_iss_set) w_busy_nxt[iss_rd]  = 1'b1;
    w_busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed cycle-vector bench for regfile_wb_arbiter with a negedge-commit RF model.
module tb_regfile_wb_arbiter;
  localparam int N  = 2;
  localparam int XW = 32;
  localparam int AW = 5;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_rd;
  logic [N*XW-1:0]   req_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd, iss_rs1, iss_rs2;
  logic              iss_stall;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [XW-1:0]     rf_wdata;

  logic [XW-1:0]     rf_mem [32];

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd), .req_data(req_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_stall(iss_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: commits on the falling edge of the rf_we cycle.
  always @(negedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  typedef struct {
    logic [1:0]  vld;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic        iv;
    logic [4:0]  ird, rs1, rs2;
    logic [1:0]  rdy;
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rfc;
    logic [4:0]  rfi;
    logic [31:0] rfv;
  } vec_t;

  vec_t tv [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] vld, input logic [4:0] rd0, input logic [4:0] rd1,
                       input logic [31:0] d0, input logic [31:0] d1, input logic iv,
                       input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2);
    req_valid = vld;
    req_rd    = {rd1, rd0};
    req_data  = {d1, d0};
    iss_valid = iv;
    iss_rd    = ird;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
  endtask

  initial begin
    //        vld    rd0 rd1 d0            d1            iv   ird rs1 rs2  rdy   st  we  waddr wdata         rfc rfi rfv
    tv[0]  = '{2'b11, 5,  6, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 0, 0, 0, 2'b01, 1'b0, 1'b1, 5,  32'h0000_00A0, 1'b0, 0, 32'h0};
    tv[1]  = '{2'b11, 5,  6, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 0, 0, 0, 2'b10, 1'b0, 1'b1, 6,  32'h0000_00B1, 1'b1, 5, 32'h0000_00A0};
    tv[2]  = '{2'b11, 5,  6, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 0, 0, 0, 2'b01, 1'b0, 1'b1, 5,  32'h0000_00A0, 1'b1, 6, 32'h0000_00B1};
    tv[3]  = '{2'b11, 5,  6, 32'h0000_00A0, 32'h0000_00B1, 1'b0, 0, 0, 0, 2'b10, 1'b0, 1'b1, 6,  32'h0000_00B1, 1'b0, 0, 32'h0};
    tv[4]  = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b0, 0, 0, 0, 2'b00, 1'b0, 1'b0, 0,  32'h0,         1'b0, 0, 32'h0};
    tv[5]  = '{2'b10, 0,  7, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 0, 0, 2'b10, 1'b0, 1'b1, 7,  32'hDEAD_BEEF, 1'b0, 0, 32'h0};
    tv[6]  = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b1, 3, 1, 2, 2'b00, 1'b0, 1'b0, 0,  32'h0,         1'b1, 7, 32'hDEAD_BEEF};
    tv[7]  = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b1, 4, 3, 0, 2'b00, 1'b1, 1'b0, 0,  32'h0,         1'b0, 0, 32'h0};
    tv[8]  = '{2'b01, 3,  0, 32'h0000_0033, 32'h0,         1'b1, 4, 3, 0, 2'b01, 1'b1, 1'b1, 3,  32'h0000_0033, 1'b0, 0, 32'h0};
    tv[9]  = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b1, 4, 3, 0, 2'b00, 1'b1, 1'b0, 0,  32'h0,         1'b1, 3, 32'h0000_0033};
    tv[10] = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b1, 4, 3, 0, 2'b00, 1'b0, 1'b0, 0,  32'h0,         1'b0, 0, 32'h0};
    tv[11] = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b1, 4, 0, 0, 2'b00, 1'b1, 1'b0, 0,  32'h0,         1'b0, 0, 32'h0};
    tv[12] = '{2'b10, 0,  0, 32'h0,         32'h0000_0055, 1'b1, 0, 0, 0, 2'b10, 1'b0, 1'b0, 0,  32'h0,         1'b0, 0, 32'h0};
    tv[13] = '{2'b11, 10, 11, 32'h0000_00AA, 32'h0000_00BB, 1'b0, 0, 0, 0, 2'b01, 1'b0, 1'b1, 10, 32'h0000_00AA, 1'b1, 0, 32'h0};
    tv[14] = '{2'b01, 9,  0, 32'h0000_0099, 32'h0,         1'b0, 0, 0, 0, 2'b01, 1'b0, 1'b1, 9,  32'h0000_0099, 1'b1, 10, 32'h0000_00AA};
    tv[15] = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b1, 9, 0, 0, 2'b00, 1'b0, 1'b0, 0,  32'h0,         1'b0, 0, 32'h0};
    tv[16] = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b1, 0, 9, 0, 2'b00, 1'b1, 1'b0, 0,  32'h0,         1'b1, 9, 32'h0000_0099};
    tv[17] = '{2'b00, 0,  0, 32'h0,         32'h0,         1'b0, 0, 9, 0, 2'b00, 1'b0, 1'b0, 0,  32'h0,         1'b0, 0, 32'h0};

    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rst_n = 1'b0;
    drive(2'b11, 5, 6, 32'h1, 32'h2, 1'b0, 0, 0, 0);
    #3;
    chk("reset_rf_we",    32'(rf_we),     32'h0);
    chk("reset_rf_waddr", 32'(rf_waddr),  32'h0);
    chk("reset_rf_wdata", rf_wdata,       32'h0);
    chk("reset_ready",    32'(req_ready), 32'h0);
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      #1;
      if (tv[i].rfc) chk($sformatf("v%0d_rf_mem[%0d]", i, tv[i].rfi), rf_mem[tv[i].rfi], tv[i].rfv);
      drive(tv[i].vld, tv[i].rd0, tv[i].rd1, tv[i].d0, tv[i].d1, tv[i].iv, tv[i].ird, tv[i].rs1, tv[i].rs2);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_stall", i), 32'(iss_stall), 32'(tv[i].stall));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tv[i].we));
      if (tv[i].we) begin
        chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'(tv[i].waddr));
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata, tv[i].wdata);
      end
    end

    // Reset asserted while a write command is in flight and x9 is pending.
    @(negedge clk);
    drive(2'b01, 12, 0, 32'h0000_00CC, 32'h0, 1'b1, 0, 9, 0);
    #1;
    chk("mid_pre_stall", 32'(iss_stall), 32'h1);
    @(posedge clk);
    #1;
    chk("mid_pre_we", 32'(rf_we), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    32'(rf_we),     32'h0);
    chk("mid_rst_waddr", 32'(rf_waddr),  32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_stall", 32'(iss_stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 12, 13, 32'h0000_00CC, 32'h0000_00DD, 1'b1, 0, 9, 0);
    #1;
    chk("post_rst_ptr0",  32'(req_ready), 32'h1);
    chk("post_rst_stall", 32'(iss_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_waddr", 32'(rf_waddr), 32'd12);
    drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
